// File: rtl/mem_resp.sv
// rtl/mem_resp.sv - byte-addressed CPU bus responder over a word RAM with byte enables
module mem_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        W_B,
    input  logic [15:0] ABUS,
    input  logic [15:0] DBUS,
    output logic        busy,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        A1   = 2'd1,
        A2   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic        wb_q, wb_d;
    logic [15:0] abus_q, abus_d;
    logic [15:0] dbus_q, dbus_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        split;

    assign split = wb_q & abus_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            wb_q    <= 1'b0;
            abus_q  <= 16'h0000;
            dbus_q  <= 16'h0000;
            hold_q  <= 8'h00;
            rdata_q <= 16'h0000;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            wb_q    <= wb_d;
            abus_q  <= abus_d;
            dbus_q  <= dbus_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        wb_d    = wb_q;
        abus_d  = abus_q;
        dbus_d  = dbus_q;
        hold_d  = hold_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    wb_d    = W_B;
                    abus_d  = ABUS;
                    dbus_d  = DBUS;
                    state_d = A1;
                end
            end
            A1: begin
                state_d = split ? A2 : FIN;
            end
            A2: begin
                // mem_rdata here is the A1 word; its low byte is the first CPU byte
                hold_d  = mem_rdata[7:0];
                state_d = FIN;
            end
            FIN: begin
                if (!we_q) begin
                    if (split)
                        rdata_d = {hold_q, mem_rdata[15:8]};
                    else if (wb_q)
                        rdata_d = mem_rdata;
                    else if (abus_q[0])
                        rdata_d = {8'h00, mem_rdata[7:0]};
                    else
                        rdata_d = {8'h00, mem_rdata[15:8]};
                end
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = (state_q == A1) || (state_q == A2);
        mem_we    = mem_en & we_q;
        mem_addr  = 15'h0000;
        mem_be    = 2'b00;
        mem_wdata = 16'h0000;
        if (mem_en) begin
            mem_addr = (state_q == A2) ? (abus_q[15:1] + 15'd1) : abus_q[15:1];
            if (!we_q) begin
                mem_be = 2'b11;
            end else if (split) begin
                mem_be    = (state_q == A2) ? 2'b10 : 2'b01;
                mem_wdata = {dbus_q[7:0], dbus_q[15:8]};
            end else if (wb_q) begin
                mem_be    = 2'b11;
                mem_wdata = dbus_q;
            end else begin
                mem_be    = abus_q[0] ? 2'b01 : 2'b10;
                mem_wdata = {dbus_q[7:0], dbus_q[7:0]};
            end
        end
    end

    assign busy  = (state_q != IDLE);
    assign ack   = ack_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_resp.sv
// tb/tb_mem_resp.sv - scoreboard bench for mem_resp with a behavioural byte-enable RAM
module tb_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        W_B = 1'b0;
    logic [15:0] ABUS = 16'h0000;
    logic [15:0] DBUS = 16'h0000;
    logic        busy, ack, mem_en, mem_we;
    logic [15:0] rdata, mem_wdata;
    logic [14:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_rdata = 16'h0000;

    mem_resp dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .W_B(W_B), .ABUS(ABUS), .DBUS(DBUS),
        .busy(busy), .ack(ack), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:32767];
    initial for (int i = 0; i < 32768; i++) ram[i] = 16'h0000;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                if (mem_be[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
                if (mem_be[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [14:0] addr;
        logic [1:0]  be;
        logic        w;
        logic [15:0] wdata;
    } strobe_t;

    typedef struct {
        int          c;
        logic [15:0] data;
    } resp_t;

    strobe_t sb_mem[$];
    resp_t   sb_resp[$];
    int checks = 0;
    int failures = 0;
    logic [15:0] last_rd = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM strobe and every ack is popped against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (sb_mem.size() == 0) begin
                    chk("unexpected_mem_en", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    strobe_t s;
                    s = sb_mem.pop_front();
                    chk("strobe_cycle", 32'(cyc), 32'(s.c));
                    chk("mem_addr", 32'(mem_addr), 32'(s.addr));
                    chk("mem_be", 32'(mem_be), 32'(s.be));
                    chk("mem_we", 32'(mem_we), 32'(s.w));
                    if (s.w) chk("mem_wdata", 32'(mem_wdata), 32'(s.wdata));
                end
            end
            if (ack) begin
                chk("busy_in_ack", 32'(busy), 32'd0);
                if (sb_resp.size() == 0) begin
                    chk("unexpected_ack", 32'(rdata), 32'hFFFF_FFFF);
                end else begin
                    resp_t r;
                    r = sb_resp.pop_front();
                    chk("ack_cycle", 32'(cyc), 32'(r.c));
                    chk("rdata", 32'(rdata), 32'(r.data));
                end
            end
        end
    end

    // Drives one request; expected strobes derive from the byte-order rules,
    // expected read data is the hand-computed value passed in.
    task automatic issue(input logic w, input logic wb, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] exp_rd);
        logic        sp;
        logic [14:0] wa;
        int          n;
        strobe_t     s;
        resp_t       r;
        sp = wb & a[0];
        wa = a[15:1];
        req = 1'b1; we = w; W_B = wb; ABUS = a; DBUS = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        n = cyc;
        s.c = n; s.addr = wa; s.w = w;
        if (!w) begin
            s.be = 2'b11; s.wdata = 16'h0000;
        end else if (sp) begin
            s.be = 2'b01; s.wdata = {d[7:0], d[15:8]};
        end else if (wb) begin
            s.be = 2'b11; s.wdata = d;
        end else begin
            s.be = a[0] ? 2'b01 : 2'b10; s.wdata = {d[7:0], d[7:0]};
        end
        sb_mem.push_back(s);
        if (sp) begin
            s.c = n + 1; s.addr = wa + 15'd1;
            if (w) s.be = 2'b10;
            sb_mem.push_back(s);
        end
        if (!w) last_rd = exp_rd;
        r.c = sp ? n + 3 : n + 2;
        r.data = last_rd;
        sb_resp.push_back(r);
    endtask

    task automatic wait_ack();
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ack) seen = 1;
        end
        chk("ack_timeout", 32'(seen), 32'd1);
    endtask

    task automatic xfer(input logic w, input logic wb, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd);
        issue(w, wb, a, d, exp_rd);
        wait_ack();
    endtask

    initial begin
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        xfer(1, 1, 16'h0010, 16'hBEEF, 16'h0000);
        xfer(0, 1, 16'h0010, 16'h0000, 16'hBEEF);
        xfer(1, 0, 16'h0011, 16'h0055, 16'h0000);
        xfer(0, 0, 16'h0010, 16'h0000, 16'h00BE);
        xfer(0, 0, 16'h0011, 16'h0000, 16'h0055);
        xfer(0, 1, 16'h0010, 16'h0000, 16'hBE55);
        xfer(1, 1, 16'h0021, 16'h1234, 16'h0000);
        xfer(0, 1, 16'h0021, 16'h0000, 16'h1234);
        xfer(0, 0, 16'h0021, 16'h0000, 16'h0012);
        xfer(0, 0, 16'h0022, 16'h0000, 16'h0034);
        xfer(1, 1, 16'hFFFF, 16'hA1B2, 16'h0000);
        xfer(0, 1, 16'hFFFF, 16'h0000, 16'hA1B2);
        xfer(0, 0, 16'h0000, 16'h0000, 16'h00B2);

        // A request pulsed while busy must vanish without a RAM cycle or ack.
        issue(1, 0, 16'h0030, 16'h0077, 16'h0000);
        req = 1'b1; we = 1'b1; W_B = 1'b1; ABUS = 16'h0040; DBUS = 16'h9999;
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_ack();
        repeat (3) @(negedge clk);
        xfer(0, 1, 16'h0040, 16'h0000, 16'h0000);
        xfer(0, 0, 16'h0030, 16'h0000, 16'h0077);
        xfer(0, 1, 16'h0010, 16'h0000, 16'hBE55);

        // Reset during A2 of a split read aborts it outright.
        issue(0, 1, 16'h0021, 16'h0000, 16'h1234);
        @(posedge clk);
        #2;
        chk("a2_mem_en_pre_rst", 32'(mem_en), 32'd1);
        rst = 1'b1;
        sb_mem.delete();
        sb_resp.delete();
        #1;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_rd = 16'h0000;
        repeat (4) @(negedge clk);
        xfer(0, 1, 16'h0021, 16'h0000, 16'h1234);
        xfer(0, 1, 16'h0010, 16'h0000, 16'hBE55);

        repeat (4) @(negedge clk);
        chk("mem_queue_drained", 32'(sb_mem.size()), 32'd0);
        chk("resp_queue_drained", 32'(sb_resp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $fatal(1);
    end

endmodule

// File: doc/mem_resp.md
# mem_resp

Memory-side responder for the 16-bit CPU's byte-addressed bus. Accepts one word or byte access per request and serves it from a word-organised synchronous RAM with byte enables. A word access at an odd byte address is split into two RAM cycles, and the result is returned in CPU byte order. The block sits between the CPU bus (ABUS/DBUS/W_B) and the RAM macro.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  single-cycle request pulse, sampled only while busy=0
- we  in  1  1 = write, 0 = read (sampled with req)
- W_B  in  1  1 = word (16-bit), 0 = byte (sampled with req)
- ABUS  in  16  byte address (sampled with req)
- DBUS  in  16  write data; byte writes use DBUS[7:0] (sampled with req)
- busy  out  1  1 while a request is in progress (state ≠ IDLE)
- ack  out  1  registered one-cycle completion pulse
- rdata  out  16  registered read result, valid from the ack cycle and held until the next read completes
- mem_en  out  1  RAM cycle strobe
- mem_we  out  1  RAM write strobe, qualified by mem_en
- mem_addr  out  15  RAM word address
- mem_be  out  2  byte enables; [1] selects bits [15:8], [0] selects bits [7:0]
- mem_wdata  out  16  RAM write data
- mem_rdata  in  16  RAM read data, valid the cycle after a read strobe

## Operation
- Byte order is big-endian. Byte address a maps to word a>>1. Even bytes are in bits [15:8]; odd bytes are in bits [7:0].
- "Split" = W_B=1 and ABUS[0]=1. Every other access uses a single RAM cycle.
- States: IDLE, A1, A2, FIN.
  - IDLE: on req, capture we, W_B, ABUS, DBUS, then go to A1.
  - A1: mem_en=1, mem_addr=ABUS[15:1]. Go to A2 if split, else FIN.
  - A2: mem_en=1, mem_addr=ABUS[15:1]+1 (wraps 0x7FFF→0x0000). Latch mem_rdata[7:0] into the hold byte. Go to FIN.
  - FIN: no RAM strobe. Load rdata (reads only), set ack for the next cycle. Go to IDLE.
- mem_we = captured we during A1 and A2. mem_addr, mem_be and mem_wdata are don't-care when mem_en=0.
- Write mapping:
  - Aligned word: be=11, wdata=DBUS.
  - Byte, even address: be=10, wdata={DBUS[7:0],DBUS[7:0]}.
  - Byte, odd address: be=01, same wdata as even byte.
  - Split word: A1 be=01, A2 be=10, wdata={DBUS[7:0],DBUS[15:8]} in both cycles.
- Read mapping, loaded into rdata at FIN:
  - Aligned word: mem_rdata.
  - Byte, even address: {8'h00, mem_rdata[15:8]}.
  - Byte, odd address: {8'h00, mem_rdata[7:0]}.
  - Split word: {hold, mem_rdata[15:8]}.
  - Reads drive be=11 in every RAM cycle.
- Writes leave rdata unchanged but still produce ack.
- req while busy=1 is ignored (dropped, not queued).
- req in the ack cycle is accepted, because the state is IDLE in that cycle.

## Timing
- req sampled at edge 0. Aligned/byte access: A1 cycle 1, FIN cycle 2, ack=1 in cycle 3. Split access: A1 cycle 1, A2 cycle 2, FIN cycle 3, ack in cycle 4.
- busy is high in A1, A2 and FIN, and low in the ack cycle.
- Back-to-back throughput: one aligned access per 3 cycles, one split access per 4 cycles.
- Reset values: state=IDLE, busy=0, ack=0, rdata=16'h0000, mem_en=0, mem_we=0, mem_be=00, mem_addr=0, mem_wdata=0, hold=0.
- Reset asserted mid-operation aborts immediately:
  - no further mem_en after reset assertion;
  - no ack for the aborted request;
  - rdata returns to 0.

## Test plan
- Aligned word write then read: write ABUS=0x0010, DBUS=0xBEEF → one RAM cycle, addr 0x0008, be=11, wdata 0xBEEF; ack in cycle 3. Read back → rdata=0xBEEF with ack in cycle 3.
- Byte access:
  - Write ABUS=0x0011, DBUS=0x0055 → be=01, addr 0x0008.
  - Read byte 0x0010 → 0x00BE.
  - Read byte 0x0011 → 0x0055.
  - Read word 0x0010 → 0xBE55.
- Split word: write ABUS=0x0021, DBUS=0x1234 → A1 addr 0x0010 be=01, A2 addr 0x0011 be=10, wdata=0x3412 in both, ack in cycle 4. Read word 0x0021 → 0x1234.
- Wrap: split write at ABUS=0xFFFF, DBUS=0xA1B2 → A1 addr 0x7FFF be=01, A2 addr 0x0000 be=10. Read back 0xFFFF → 0xA1B2.
- Handshake:
  - req pulsed while busy → dropped, no extra RAM cycle, exactly one ack.
  - req in the ack cycle → accepted, A1 on the following cycle.
- Reset mid split read, asserted during A2 → mem_en=0 immediately, no ack, rdata=0, busy=0; the next request completes normally.
